// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite responder with three 8-bit R/W registers and a read-only
// count of successful writes at address 3.
module axi4lite_slave_regs (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic [1:0]  s_axi_awaddr,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [7:0]  s_axi_wdata,
  input  logic        s_axi_wstrb,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [1:0]  s_axi_araddr,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [7:0]  s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [23:0] regs_out
);

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NREGS  = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_W-1:0] CNT_ADDR = ADDR_W'(3);

  logic [NREGS-1:0][DATA_W-1:0] regs_q;
  logic [DATA_W-1:0]            wcount;
  logic                         aw_held;
  logic [ADDR_W-1:0]            aw_addr;
  logic                         w_held;
  logic [DATA_W-1:0]            w_data;
  logic                         w_strb;
  logic                         commit;

  assign s_axi_awready = ~aw_held;
  assign s_axi_wready  = ~w_held;
  assign s_axi_arready = ~s_axi_rvalid;
  assign regs_out      = regs_q;

  // A held pair waits for any outstanding response to drain first.
  assign commit = aw_held & w_held & ~s_axi_bvalid;

  // Write path: independent AW/W capture, commit, and B channel.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      regs_q       <= '0;
      wcount       <= '0;
      aw_held      <= 1'b0;
      aw_addr      <= '0;
      w_held       <= 1'b0;
      w_data       <= '0;
      w_strb       <= 1'b0;
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && !aw_held) begin
        aw_held <= 1'b1;
        aw_addr <= s_axi_awaddr;
      end
      if (s_axi_wvalid && !w_held) begin
        w_held <= 1'b1;
        w_data <= s_axi_wdata;
        w_strb <= s_axi_wstrb;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        s_axi_bvalid <= 1'b0;
      end
      if (commit) begin
        aw_held      <= 1'b0;
        w_held       <= 1'b0;
        s_axi_bvalid <= 1'b1;
        if (aw_addr == CNT_ADDR) begin
          s_axi_bresp <= RESP_SLVERR;
        end else begin
          s_axi_bresp <= RESP_OKAY;
          wcount      <= wcount + DATA_W'(1);
          if (w_strb) begin
            case (aw_addr)
              2'd0:    regs_q[0] <= w_data;
              2'd1:    regs_q[1] <= w_data;
              default: regs_q[2] <= w_data;
            endcase
          end
        end
      end
    end
  end

  // Read path: capture on AR handshake, hold until R handshake.
  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (s_axi_arvalid && !s_axi_rvalid) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rresp  <= RESP_OKAY;
      case (s_axi_araddr)
        2'd0:    s_axi_rdata <= regs_q[0];
        2'd1:    s_axi_rdata <= regs_q[1];
        2'd2:    s_axi_rdata <= regs_q[2];
        default: s_axi_rdata <= wcount;
      endcase
    end else if (s_axi_rvalid && s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Directed bench for axi4lite_slave_regs: vector table plus hand-built
// sequences for reset, ordering, back-pressure, wrap and read/write collision.
module tb_axi4lite_slave_regs;

  logic        clk;
  logic        rst_n;
  logic [1:0]  awaddr;
  logic        awvalid;
  logic        awready;
  logic [7:0]  wdata;
  logic        wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [1:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [7:0]  rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [23:0] regs_out;

  int n_cmp = 0;
  int n_bad = 0;

  axi4lite_slave_regs dut (
    .m_axi_aclk    (clk),
    .m_axi_aresetn (rst_n),
    .s_axi_awaddr  (awaddr),
    .s_axi_awvalid (awvalid),
    .s_axi_awready (awready),
    .s_axi_wdata   (wdata),
    .s_axi_wstrb   (wstrb),
    .s_axi_wvalid  (wvalid),
    .s_axi_wready  (wready),
    .s_axi_bresp   (bresp),
    .s_axi_bvalid  (bvalid),
    .s_axi_bready  (bready),
    .s_axi_araddr  (araddr),
    .s_axi_arvalid (arvalid),
    .s_axi_arready (arready),
    .s_axi_rdata   (rdata),
    .s_axi_rresp   (rresp),
    .s_axi_rvalid  (rvalid),
    .s_axi_rready  (rready),
    .regs_out      (regs_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_wr;
    logic [1:0] addr;
    logic [7:0] data;
    logic       strb;
    logic [1:0] exp_resp;
    logic [7:0] exp_rdata;
    logic [23:0] exp_regs;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // AW and W in the same cycle, bready high; lat counts edges from handshake to bvalid.
  task automatic do_write(input logic [1:0] a, input logic [7:0] d, input logic s,
                          output logic [1:0] resp, output int lat);
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 8) begin
      tick();
      lat++;
    end
    resp = bresp;
    tick();
    bready = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [7:0] d,
                         output logic [1:0] resp, output int lat);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 8) begin
      tick();
      lat++;
    end
    d = rdata;
    resp = rresp;
    tick();
    rready = 1'b0;
  endtask

  // Commit of (wa,wd) lands on the same edge as the AR capture of ra.
  task automatic collide(input logic [1:0] wa, input logic [7:0] wd, input logic [1:0] ra,
                         input logic [7:0] exp_old, input logic [7:0] exp_new, input string tag);
    logic [7:0] d;
    logic [1:0] r;
    int lat;
    awaddr = wa; awvalid = 1'b1; wdata = wd; wstrb = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = ra; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0;
    check({tag, "_bvalid"}, 32'(bvalid), 32'd1);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_old"}, 32'(rdata), 32'(exp_old));
    rready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    check({tag, "_bclr"}, 32'(bvalid), 32'd0);
    do_read(ra, d, r, lat);
    check({tag, "_new"}, 32'(d), 32'(exp_new));
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] r;
    int lat;

    vecs[0]  = '{1'b1, 2'd1, 8'hA5, 1'b1, 2'b00, 8'h00, 24'h00A500};
    vecs[1]  = '{1'b0, 2'd1, 8'h00, 1'b0, 2'b00, 8'hA5, 24'h00A500};
    vecs[2]  = '{1'b1, 2'd3, 8'h11, 1'b1, 2'b10, 8'h00, 24'h00A500};
    vecs[3]  = '{1'b0, 2'd3, 8'h00, 1'b0, 2'b00, 8'h01, 24'h00A500};
    vecs[4]  = '{1'b1, 2'd0, 8'hFF, 1'b0, 2'b00, 8'h00, 24'h00A500};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'b00, 8'h00, 24'h00A500};
    vecs[6]  = '{1'b0, 2'd3, 8'h00, 1'b0, 2'b00, 8'h02, 24'h00A500};
    vecs[7]  = '{1'b1, 2'd2, 8'hC3, 1'b1, 2'b00, 8'h00, 24'hC3A500};
    vecs[8]  = '{1'b1, 2'd0, 8'h7E, 1'b1, 2'b00, 8'h00, 24'hC3A57E};
    vecs[9]  = '{1'b0, 2'd2, 8'h00, 1'b0, 2'b00, 8'hC3, 24'hC3A57E};
    vecs[10] = '{1'b0, 2'd3, 8'h00, 1'b0, 2'b00, 8'h04, 24'hC3A57E};

    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = 1'b0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst0_awready", 32'(awready), 32'd1);
    check("rst0_arready", 32'(arready), 32'd1);
    check("rst0_bvalid", 32'(bvalid), 32'd0);
    check("rst0_regs", 32'(regs_out), 32'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();

    // Dirty the state, then reset with a write address held.
    do_write(2'd0, 8'h5A, 1'b1, r, lat);
    do_read(2'd0, d, r, lat);
    check("pre_rst_rd", 32'(d), 32'h5A);
    awaddr = 2'd1; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("pre_rst_awready", 32'(awready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_regs", 32'(regs_out), 32'd0);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd1);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_bvalid", 32'(bvalid), 32'd0);
      check("post_rst_regs", 32'(regs_out), 32'd0);
    end

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, r, lat);
        check($sformatf("v%0d_blat", i), 32'(lat), 32'd1);
        check($sformatf("v%0d_bresp", i), 32'(r), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, d, r, lat);
        check($sformatf("v%0d_rlat", i), 32'(lat), 32'd0);
        check($sformatf("v%0d_rdata", i), 32'(d), 32'(vecs[i].exp_rdata));
        check($sformatf("v%0d_rresp", i), 32'(r), 32'd0);
      end
      check($sformatf("v%0d_regs", i), 32'(regs_out), 32'(vecs[i].exp_regs));
    end

    // W first, AW three cycles later, B back-pressured; second pair waits.
    bready = 1'b0;
    wdata = 8'h66; wstrb = 1'b1; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("wfirst_wready", 32'(wready), 32'd0);
    tick();
    tick();
    check("wfirst_bvalid", 32'(bvalid), 32'd0);
    awaddr = 2'd2; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("wfirst_awready", 32'(awready), 32'd0);
    check("wfirst_nocommit", 32'(bvalid), 32'd0);
    tick();
    check("wfirst_bvalid1", 32'(bvalid), 32'd1);
    check("wfirst_regs", 32'(regs_out), 32'h66A57E);
    check("wfirst_awready1", 32'(awready), 32'd1);
    awaddr = 2'd1; awvalid = 1'b1; wdata = 8'h99; wvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      awvalid = 1'b0; wvalid = 1'b0;
      check("bstall_bvalid", 32'(bvalid), 32'd1);
      check("bstall_bresp", 32'(bresp), 32'd0);
      check("bstall_awready", 32'(awready), 32'd0);
      check("bstall_regs", 32'(regs_out), 32'h66A57E);
    end
    bready = 1'b1;
    tick();
    check("bhs_bvalid", 32'(bvalid), 32'd0);
    check("bhs_regs", 32'(regs_out), 32'h66A57E);
    tick();
    check("second_bvalid", 32'(bvalid), 32'd1);
    check("second_bresp", 32'(bresp), 32'd0);
    check("second_regs", 32'(regs_out), 32'h6699_7E);
    tick();
    bready = 1'b0;
    check("second_bclr", 32'(bvalid), 32'd0);

    // R back-pressure on address 2.
    araddr = 2'd2; arvalid = 1'b1; rready = 1'b0;
    tick();
    arvalid = 1'b0; araddr = 2'd0;
    for (int i = 0; i < 3; i++) begin
      check("rstall_rvalid", 32'(rvalid), 32'd1);
      check("rstall_rdata", 32'(rdata), 32'h66);
      check("rstall_arready", 32'(arready), 32'd0);
      if (i < 2) tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rhs_rvalid", 32'(rvalid), 32'd0);
    check("rhs_arready", 32'(arready), 32'd1);

    // wcount is 6; 250 OKAY writes wrap it through 255 to 0.
    do_read(2'd3, d, r, lat);
    check("cnt_before_wrap", 32'(d), 32'd6);
    for (int i = 0; i < 250; i++) begin
      do_write(2'd0, 8'(i), 1'b1, r, lat);
      check("wrap_bresp", 32'(r), 32'd0);
    end
    do_read(2'd3, d, r, lat);
    check("cnt_wrapped", 32'(d), 32'd0);
    check("wrap_regs", 32'(regs_out), 32'h6699F9);

    collide(2'd2, 8'h3C, 2'd2, 8'h66, 8'h3C, "col_r2");
    collide(2'd0, 8'h01, 2'd3, 8'h01, 8'h02, "col_cnt");
    check("final_regs", 32'(regs_out), 32'h3C9901);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
